dpram_frame_reader: RTL and testbench
=====================================

# dpram_frame_reader

Port-B read engine for the audio-path dual-port RAM. The capture side writes audio samples into one half (bank) of the DPRAM through port A and pulses `frame_ready`. This block then reads that bank out through port B and presents the samples as a valid/ready stream to downstream processing. Read latency is absorbed in a small skid FIFO, so the stream sustains one word per cycle under backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: DPRAM port-B address width. Bit `ADDR_WIDTH-1` selects the bank.
- `DATA_WIDTH`, 18: sample width. Equals the DPRAM port-B data width.
- `FRAME_LEN`, 512: words per frame. Range 1..2^(ADDR_WIDTH-1).

Ports:
- `b_clk`, in, 1: single clock, shared with DPRAM port B.
- `b_rst_n`, in, 1: asynchronous, active-low reset.
- `frame_ready`, in, 1: one-cycle pulse from the writer. The bank is given by `frame_bank`.
- `frame_bank`, in, 1: bank just completed by the writer.
- `b_addr`, out, ADDR_WIDTH: registered DPRAM port-B address.
- `b_rd_data`, in, DATA_WIDTH: DPRAM port-B read data.
- `out_data`, out, DATA_WIDTH: stream data.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready.
- `out_last`, out, 1: asserted with the final word of a frame.
- `busy`, out, 1: high from frame acceptance until the last word is transferred.
- `overrun`, out, 1: sticky error flag. Cleared only by reset.

DPRAM port-B write enable is tied low at the top level; this block never writes.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - A `frame_ready` pulse, or a pending request, latches the bank.
  - `b_addr` is set to {bank, 0} and the FSM goes to READ.
- READ, issuing reads:
  - A read is issued in a cycle only if FIFO occupancy plus in-flight reads is less than FIFO depth.
  - Each issue increments the word index. The address is {bank, index}.
  - After issuing index FRAME_LEN-1, the FSM goes to DRAIN.
- READ, read data: each in-flight read's data is pushed into the FIFO LAT cycles after issue.
  - LAT = 1 without the macro, 2 with it.
  - FIFO depth = LAT+1.
- DRAIN: when the FIFO is empty and nothing is in flight, the FSM goes to IDLE, or straight to READ if a request is pending.
- Pending request:
  - One entry: bank plus a valid bit.
  - A `frame_ready` while `busy` sets pending.
  - A `frame_ready` while pending is already set sets `overrun` and is dropped; the first pending request is kept.
- Simultaneous frame completion and new `frame_ready`: the new request is taken as pending, with no overrun.
- `out_last` is asserted on the word with index FRAME_LEN-1 while that word is at the FIFO head.
- Stream transfer occurs when `out_valid` and `out_ready` are both high.
- `out_valid` and `out_data` are held stable while `out_ready` is low.
- Index counter width is ADDR_WIDTH-1. The counter never wraps within a frame; it resets to 0 at each frame start.

## Timing
- Reset values:
  - `b_addr` = 0, `out_data` = 0.
  - `out_valid`, `out_last`, `busy`, `overrun` = 0.
  - FSM = IDLE, pending cleared, FIFO empty.
- `frame_ready` sampled at edge N in IDLE:
  - `busy` and `b_addr` = {bank, 0} are set after edge N.
  - `out_valid` first rises after edge N+1+LAT.
- With `out_ready` held high:
  - FRAME_LEN consecutive `out_valid` cycles, with no bubbles.
  - `busy` falls the cycle after the `out_last` transfer.
- Back-to-back frames with a pending request: at most LAT+1 idle cycles between the `out_last` transfer and the next `out_valid`.
- Reset asserted mid-frame: everything returns immediately to reset values. The frame is discarded and the pending request is lost.

## Configuration
- `DPRAM_RD_OUTREG_EN`:
  - Defined: the DPRAM is built with its port-B output register. LAT=2, FIFO depth 3, plus one extra in-flight stage.
  - Undefined: LAT=1, FIFO depth 2.

## Structure
- Package `dpram_rd_pkg`:
  - FSM state enum.
  - `LAT` and `FIFO_DEPTH` localparams, derived under the macro.
- Sub-module `dpram_rd_skid_fifo`:
  - Parameterised depth and width.
  - Interface: push, pop, occupancy count, head data.
  - Resets asynchronously with `b_rst_n`.

## Test plan
- Single frame, `out_ready`=1:
  - Writer fills bank 0 with a descending count from 0x3FFFF, then pulses `frame_ready`.
  - Required: 512 words 0x3FFFF..0x3FE00 in order, `out_last` on the 512th word only, `out_valid` first rises 2 cycles after the pulse (3 with the macro).
- Backpressure:
  - `out_ready` toggles on a random 50% pattern.
  - Required: no word lost or duplicated, `out_data` stable whenever `out_valid` is high and `out_ready` is low, and the FIFO never exceeds its depth.
- Ping-pong:
  - Pulse bank 1 at mid-frame of bank 0.
  - Required: bank 1 is streamed right after bank 0, within ≤2 idle cycles (≤3 with the macro), and `overrun`=0.
- Overrun:
  - Three pulses during one busy frame.
  - Required: `overrun`=1 and stays 1, and only the first pending frame is streamed.
- Reset mid-frame:
  - Assert `b_rst_n`=0 at word 100.
  - Required: outputs go to reset values at once; after release and a new pulse, the frame restarts at index 0.
- FRAME_LEN=1:
  - Required: a single word with `out_valid` and `out_last` both high, then `busy`=0.

Source files
------------

// File: rtl/dpram_rd_pkg.sv
// rtl/dpram_rd_pkg.sv - FSM state and read-latency constants for the DPRAM frame reader
// DPRAM_RD_OUTREG_EN: port-B output register present, read latency 2 instead of 1.
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

`ifdef DPRAM_RD_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // One slot per in-flight read plus one for the word being presented.
    localparam int FIFO_DEPTH = LAT + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/dpram_rd_skid_fifo.sv
// rtl/dpram_rd_skid_fifo.sv - small skid FIFO absorbing DPRAM read latency
// Head entry is presented combinationally; storage resets to zero so the head reads 0 after reset.
module dpram_rd_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 19,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             b_clk,
    input  logic             b_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != CW'(DEPTH)) || do_pop);
        head_data = mem[rd_ptr];
    end

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_frame_reader.sv
// rtl/dpram_frame_reader.sv - DPRAM port-B frame reader streaming one bank per frame_ready
// DPRAM_RD_OUTREG_EN (via dpram_rd_pkg) selects the two-cycle read latency build.
module dpram_frame_reader
    import dpram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18,
    parameter int FRAME_LEN  = 512
) (
    input  logic                  b_clk,
    input  logic                  b_rst_n,
    input  logic                  frame_ready,
    input  logic                  frame_bank,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int IW = ADDR_WIDTH - 1;
    localparam int FW = DATA_WIDTH + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    rd_state_t        state;
    logic             cur_bank;
    logic             pend_vld;
    logic             pend_bank;
    logic [IW-1:0]    idx;
    logic [LAT-1:0]   rd_vld;
    logic [LAT-1:0]   rd_last;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [FW-1:0]    fifo_head;
    logic             pop;
    logic             issue;
    logic             drain_done;

    dpram_rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .b_clk     (b_clk),
        .b_rst_n   (b_rst_n),
        .push      (rd_vld[LAT-1]),
        .push_data ({rd_last[LAT-1], b_rd_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // Room is judged after this cycle's pop so a full-rate stream never bubbles.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(rd_vld[i]);
        end
        out_valid  = (fifo_count != '0);
        out_data   = fifo_head[DATA_WIDTH-1:0];
        out_last   = out_valid && fifo_head[FW-1];
        pop        = out_valid && out_ready;
        issue      = (state == READ) &&
                     ((int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + (pop ? 1 : 0)));
        drain_done = (state == DRAIN) && (inflight == '0) &&
                     (int'(fifo_count) == (pop ? 1 : 0));
    end

    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            state     <= IDLE;
            b_addr    <= '0;
            idx       <= '0;
            cur_bank  <= 1'b0;
            pend_vld  <= 1'b0;
            pend_bank <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            rd_vld    <= '0;
            rd_last   <= '0;
        end else begin
            rd_vld[0]  <= issue;
            rd_last[0] <= issue && (idx == LAST_IDX);
            for (int i = 1; i < LAT; i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_last[i] <= rd_last[i-1];
            end

            case (state)
                IDLE: begin
                    if (pend_vld) begin
                        state     <= READ;
                        cur_bank  <= pend_bank;
                        b_addr    <= {pend_bank, {IW{1'b0}}};
                        idx       <= '0;
                        busy      <= 1'b1;
                        pend_vld  <= frame_ready;
                        pend_bank <= frame_bank;
                    end else if (frame_ready) begin
                        state    <= READ;
                        cur_bank <= frame_bank;
                        b_addr   <= {frame_bank, {IW{1'b0}}};
                        idx      <= '0;
                        busy     <= 1'b1;
                    end
                end

                READ: begin
                    if (issue) begin
                        idx    <= idx + IW'(1);
                        b_addr <= {cur_bank, idx + IW'(1)};
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                    if (frame_ready) begin
                        if (pend_vld) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_vld  <= 1'b1;
                            pend_bank <= frame_bank;
                        end
                    end
                end

                DRAIN: begin
                    // A request arriving on the completing cycle replaces the one being consumed.
                    if (drain_done) begin
                        if (pend_vld) begin
                            state    <= READ;
                            cur_bank <= pend_bank;
                            b_addr   <= {pend_bank, {IW{1'b0}}};
                            idx      <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        pend_vld  <= frame_ready;
                        pend_bank <= frame_bank;
                    end else if (frame_ready) begin
                        if (pend_vld) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_vld  <= 1'b1;
                            pend_bank <= frame_bank;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_frame_reader.sv
// tb/tb_dpram_frame_reader.sv - scoreboard bench for dpram_frame_reader with a behavioural DPRAM
// DPRAM_RD_OUTREG_EN: adds the port-B output register stage to the RAM model.
module tb_dpram_frame_reader;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int FL = 512;
`ifdef DPRAM_RD_OUTREG_EN
    localparam int TB_LAT = 2;
`else
    localparam int TB_LAT = 1;
`endif

    logic          b_clk   = 1'b0;
    logic          b_rst_n = 1'b1;
    logic          frame_ready = 1'b0;
    logic          frame_bank  = 1'b0;
    logic          out_ready   = 1'b0;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, busy, overrun;

    logic          frame_ready1 = 1'b0;
    logic          frame_bank1  = 1'b0;
    logic          out_ready1   = 1'b0;
    logic [AW-1:0] b_addr1;
    logic [DW-1:0] b_rd_data1;
    logic [DW-1:0] out_data1;
    logic          out_valid1, out_last1, busy1, overrun1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q, rd_q1;
    logic [DW:0]   sb_q [$];
    logic [DW:0]   exp_w;
    int            checks   = 0;
    int            errors   = 0;
    int            rx_count = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;

    always #5 b_clk = ~b_clk;

    always @(posedge b_clk) begin
        rd_q  <= mem[b_addr];
        rd_q1 <= mem[b_addr1];
    end
`ifdef DPRAM_RD_OUTREG_EN
    logic [DW-1:0] rd_q2, rd_q12;
    always @(posedge b_clk) begin
        rd_q2  <= rd_q;
        rd_q12 <= rd_q1;
    end
    assign b_rd_data  = rd_q2;
    assign b_rd_data1 = rd_q12;
`else
    assign b_rd_data  = rd_q;
    assign b_rd_data1 = rd_q1;
`endif

    dpram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL)) u_dut (
        .b_clk(b_clk), .b_rst_n(b_rst_n), .frame_ready(frame_ready), .frame_bank(frame_bank),
        .b_addr(b_addr), .b_rd_data(b_rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    dpram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(1)) u_dut1 (
        .b_clk(b_clk), .b_rst_n(b_rst_n), .frame_ready(frame_ready1), .frame_bank(frame_bank1),
        .b_addr(b_addr1), .b_rd_data(b_rd_data1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_last(out_last1), .busy(busy1), .overrun(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_bank(input logic bank, input int seed, input bit desc);
        for (int i = 0; i < FL; i++) begin
            if (desc) mem[int'(bank) * FL + i] = DW'(32'h3FFFF - i);
            else      mem[int'(bank) * FL + i] = DW'((i * seed + 32'h155) ^ (seed << 4));
        end
    endtask

    task automatic pulse(input logic bank, input bit accept);
        @(posedge b_clk); #1;
        frame_ready = 1'b1;
        frame_bank  = bank;
        if (accept) begin
            for (int i = 0; i < FL; i++) sb_q.push_back({(i == FL - 1), mem[int'(bank) * FL + i]});
        end
        @(posedge b_clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, input bit rand_rdy);
        bit done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(posedge b_clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            done = !busy && !out_valid && (sb_q.size() == 0);
        end
        out_ready = 1'b1;
        check(tag, 32'(done), 1);
    endtask

    // Scoreboard pop and hold-stability monitor, sampled mid-cycle.
    always @(negedge b_clk) begin
        if (!b_rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_w = sb_q.pop_front();
                    check("word_data", 32'(out_data), 32'(exp_w[DW-1:0]));
                    check("word_last", 32'(out_last), 32'(exp_w[DW]));
                end
                rx_count++;
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vcnt;
        int idle;
        int base;
        bit seen;

        out_ready = 1'b1;
        #2 b_rst_n = 1'b0;
        repeat (3) @(posedge b_clk);
        #1;
        check("rst_b_addr", 32'(b_addr), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        b_rst_n = 1'b1;
        repeat (2) @(posedge b_clk);

        // Single frame, descending count, full rate
        fill_bank(1'b0, 0, 1'b1);
        pulse(1'b0, 1'b1);
        @(negedge b_clk);
        check("t1_busy", 32'(busy), 1);
        check("t1_b_addr", 32'(b_addr), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge b_clk);
            lat++;
        end
        check("t1_first_valid_lat", lat, TB_LAT + 1);
        vcnt = 0;
        for (int i = 0; i < FL; i++) begin
            if (out_valid) vcnt++;
            @(negedge b_clk);
        end
        check("t1_valid_run", vcnt, FL);
        check("t1_busy_fall", 32'(busy), 0);
        check("t1_valid_fall", 32'(out_valid), 0);
        check("t1_sb_empty", sb_q.size(), 0);

        // Random backpressure
        fill_bank(1'b1, 37, 1'b0);
        pulse(1'b1, 1'b1);
        wait_done("t2_done", 5000, 1'b1);
        check("t2_overrun", 32'(overrun), 0);

        // Ping-pong: bank 1 requested mid-way through bank 0
        fill_bank(1'b0, 11, 1'b0);
        fill_bank(1'b1, 53, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (256) @(posedge b_clk);
        pulse(1'b1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge b_clk);
            seen = out_valid && out_ready && out_last;
        end
        check("t3_first_last_seen", 32'(seen), 1);
        idle = 0;
        @(negedge b_clk);
        while (!out_valid && idle < 20) begin
            idle++;
            @(negedge b_clk);
        end
        check("t3_gap", (idle > TB_LAT + 1) ? idle : TB_LAT + 1, TB_LAT + 1);
        wait_done("t3_done", 2000, 1'b0);
        check("t3_overrun", 32'(overrun), 0);

        // Overrun: three requests during one busy frame
        fill_bank(1'b0, 71, 1'b0);
        fill_bank(1'b1, 91, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (50) @(posedge b_clk);
        pulse(1'b1, 1'b1);
        repeat (10) @(posedge b_clk);
        pulse(1'b0, 1'b0);
        repeat (10) @(posedge b_clk);
        pulse(1'b1, 1'b0);
        @(negedge b_clk);
        check("t4_overrun_set", 32'(overrun), 1);
        wait_done("t4_done", 4000, 1'b0);
        repeat (20) @(negedge b_clk);
        check("t4_no_extra_valid", 32'(out_valid), 0);
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_overrun_sticky", 32'(overrun), 1);

        // Reset mid-frame
        fill_bank(1'b1, 23, 1'b0);
        base = rx_count;
        pulse(1'b1, 1'b1);
        repeat (20) @(posedge b_clk);
        pulse(1'b0, 1'b0);
        for (int c = 0; c < 2000 && (rx_count - base) < 100; c++) @(negedge b_clk);
        check("t5_reached_word100", 32'(rx_count - base >= 100), 1);
        @(posedge b_clk); #1;
        b_rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_last", 32'(out_last), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_overrun", 32'(overrun), 0);
        check("t5_rst_b_addr", 32'(b_addr), 0);
        check("t5_rst_out_data", 32'(out_data), 0);
        sb_q.delete();
        repeat (2) @(posedge b_clk);
        #1 b_rst_n = 1'b1;
        repeat (5) @(negedge b_clk);
        check("t5_pending_lost_valid", 32'(out_valid), 0);
        check("t5_pending_lost_busy", 32'(busy), 0);
        pulse(1'b1, 1'b1);
        @(negedge b_clk);
        check("t5_restart_b_addr", 32'(b_addr), FL);
        wait_done("t5_done", 2000, 1'b0);

        // FRAME_LEN = 1 instance
        mem[FL] = 18'h2A5A5;
        out_ready1 = 1'b1;
        @(posedge b_clk); #1;
        frame_ready1 = 1'b1;
        frame_bank1  = 1'b1;
        @(posedge b_clk); #1;
        frame_ready1 = 1'b0;
        @(negedge b_clk);
        check("t6_busy", 32'(busy1), 1);
        check("t6_b_addr", 32'(b_addr1), FL);
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(negedge b_clk);
            lat++;
        end
        check("t6_first_valid_lat", lat, TB_LAT + 1);
        check("t6_last", 32'(out_last1), 1);
        check("t6_data", 32'(out_data1), 32'h2A5A5);
        @(negedge b_clk);
        check("t6_busy_fall", 32'(busy1), 0);
        check("t6_valid_fall", 32'(out_valid1), 0);
        check("t6_overrun", 32'(overrun1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
